// File: rtl/program_loader_if.sv
// Byte-source and instruction-memory write bundle for program_loader.
// master drives bytes and observes the loader; slave is the loader itself.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [15:0]           o_wr_data;
    logic                  o_core_hold;
    logic                  o_done;
    logic                  o_error;

    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        input  o_core_hold, o_done, o_error
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        output o_core_hold, o_done, o_error
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader into instruction memory (A5, L, words, xor).
// Define LOADER_TIMEOUT_EN to abort a stalled frame after TIMEOUT_CLKS.
module program_loader #(
    parameter int ADDR_WIDTH   = 8,
    parameter int TIMEOUT_CLKS = 65535
) (
    input logic              i_clk,
    input logic              i_rst_n,
    program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO,
        S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                state, state_n;
    logic [7:0]            hi_q, hi_n;
    logic [7:0]            xor_q, xor_n;
    logic [8:0]            cnt_q, cnt_n;
    logic [8:0]            len_q, len_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [ADDR_WIDTH-1:0] wa_q, wa_n;
    logic [15:0]           wd_q, wd_n;
    logic                  hold_q, hold_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic                  rdy;
    logic                  acc;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0]           tmr_q, tmr_n;
`else
    logic [31:0]           unused_tmo;
    assign unused_tmo = TIMEOUT_CLKS;
`endif

    assign rdy = (state != S_WRITE);
    assign acc = bus.i_byte_valid && rdy;

    assign bus.o_byte_ready = rdy;
    assign bus.o_wr_en      = (state == S_WRITE);
    assign bus.o_wr_addr    = wa_q;
    assign bus.o_wr_data    = wd_q;
    assign bus.o_core_hold  = hold_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = err_q;

    always_comb begin
        state_n = state;
        hi_n    = hi_q;
        xor_n   = xor_q;
        cnt_n   = cnt_q;
        len_n   = len_q;
        addr_n  = addr_q;
        wa_n    = wa_q;
        wd_n    = wd_q;
        hold_n  = hold_q;
        done_n  = done_q;
        err_n   = err_q;
`ifdef LOADER_TIMEOUT_EN
        tmr_n   = tmr_q;
`endif
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (acc && bus.i_byte == 8'hA5) begin
                    state_n = S_LEN;
                    hold_n  = 1'b1;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    addr_n  = '0;
                    xor_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_LEN: begin
                if (acc) begin
                    // a zero length byte encodes a full 256-word image
                    len_n   = (bus.i_byte == 8'h00) ? 9'd256
                                                    : {1'b0, bus.i_byte};
                    xor_n   = bus.i_byte;
                    state_n = S_HI;
                end
            end
            S_HI: begin
                if (acc) begin
                    hi_n    = bus.i_byte;
                    xor_n   = xor_q ^ bus.i_byte;
                    state_n = S_LO;
                end
            end
            S_LO: begin
                if (acc) begin
                    xor_n   = xor_q ^ bus.i_byte;
                    wa_n    = addr_q;
                    wd_n    = {hi_q, bus.i_byte};
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_n  = addr_q + 1'b1;
                cnt_n   = cnt_q + 9'd1;
                state_n = (cnt_q + 9'd1 == len_q) ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (acc) begin
                    if (bus.i_byte == xor_q) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
                    end else begin
                        state_n = S_ERROR;
                        err_n   = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // silence mid-frame aborts with the core still held
        if (state == S_LEN || state == S_HI ||
            state == S_LO  || state == S_CHECK) begin
            if (acc) begin
                tmr_n = '0;
            end else if (tmr_q == 32'(TIMEOUT_CLKS - 1)) begin
                tmr_n   = '0;
                state_n = S_ERROR;
                err_n   = 1'b1;
            end else begin
                tmr_n = tmr_q + 32'd1;
            end
        end else begin
            tmr_n = '0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            hi_q   <= '0;
            xor_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            wa_q   <= '0;
            wd_q   <= '0;
            hold_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            hi_q   <= hi_n;
            xor_q  <= xor_n;
            cnt_q  <= cnt_n;
            len_q  <= len_n;
            addr_q <= addr_n;
            wa_q   <= wa_n;
            wd_q   <= wd_n;
            hold_q <= hold_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tmr_q <= '0;
        else          tmr_q <= tmr_n;
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames in, expected writes queued,
// a negedge monitor pops and compares each write strobe.
module tb_program_loader;

    localparam int TMO = 16;

    typedef logic [15:0] wq_t[$];
    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    wr_t  exp_q[$];
    logic m_done, m_err, m_hold;

    program_loader_if #(.ADDR_WIDTH(8)) bus ();

    program_loader #(
        .ADDR_WIDTH  (8),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if (bus.o_byte_ready !== !bus.o_wr_en) begin
                n_err++;
                $display("FAIL ready_vs_write: ready=%b wr_en=%b",
                         bus.o_byte_ready, bus.o_wr_en);
            end
            if (bus.o_wr_en === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h",
                             bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (bus.o_wr_addr !== e.a || bus.o_wr_data !== e.d) begin
                        n_err++;
                        $display("FAIL write: got %0h:%0h want %0h:%0h",
                                 bus.o_wr_addr, bus.o_wr_data, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit cont,
                             input int gap_max);
        int k;
        @(negedge clk);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        k = 0;
        while (bus.o_byte_ready !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (bus.o_byte_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL stall: byte %0h never accepted", b);
        end
        @(posedge clk);
        #1;
        if (!cont) begin
            bus.i_byte_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    task automatic check_flags(input string nm);
        chk({nm, "_done"}, {31'd0, bus.o_done}, {31'd0, m_done});
        chk({nm, "_error"}, {31'd0, bus.o_error}, {31'd0, m_err});
        chk({nm, "_hold"}, {31'd0, bus.o_core_hold}, {31'd0, m_hold});
    endtask

    // reference: writes go to addresses 0..n-1; good iff checksum
    // equals L xor every data byte
    task automatic run_frame(input wq_t w, input logic [7:0] flip,
                             input bit cont, input string nm);
        logic [7:0] l;
        logic [7:0] x;
        wr_t        e;
        l = 8'(w.size());
        x = l;
        for (int i = 0; i < w.size(); i++) begin
            e.a = 8'(i);
            e.d = w[i];
            exp_q.push_back(e);
            x = x ^ w[i][15:8] ^ w[i][7:0];
        end
        send_byte(8'hA5, cont, 2);
        chk({nm, "_hold_hdr"}, {31'd0, bus.o_core_hold}, 32'd1);
        send_byte(l, cont, 2);
        for (int i = 0; i < w.size(); i++) begin
            send_byte(w[i][15:8], cont, 2);
            send_byte(w[i][7:0], cont, 2);
        end
        send_byte(x ^ flip, 1'b0, 0);
        m_done = (flip == 8'h00);
        m_err  = (flip != 8'h00);
        m_hold = (flip != 8'h00);
        check_flags(nm);
        chk({nm, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t        w;
        logic [7:0] b;
        n_vec = 0;
        n_err = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.o_byte_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, bus.o_wr_en}, 32'd0);
        chk("rst_addr", {24'd0, bus.o_wr_addr}, 32'd0);
        chk("rst_data", {16'd0, bus.o_wr_data}, 32'd0);
        check_flags("rst");
        rst_n = 1'b1;

        w = {16'h1234, 16'h5678};
        run_frame(w, 8'h00, 1'b0, "good");

        run_frame(w, 8'h01, 1'b0, "badck");
        w = {16'hA5A5, 16'h00FF, 16'h5A01};
        run_frame(w, 8'h00, 1'b0, "recover");

        send_byte(8'h00, 1'b0, 1);
        send_byte(8'hFF, 1'b0, 1);
        send_byte(8'h5A, 1'b0, 1);
        @(negedge clk);
        check_flags("noise");
        w = {16'hABCD};
        run_frame(w, 8'h00, 1'b0, "post_noise");

        w = {16'h0102, 16'h0304, 16'h0506, 16'h0708};
        run_frame(w, 8'h00, 1'b1, "backpr");

        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.o_byte_ready}, 32'd1);
        chk("mid_rst_wr_en", {31'd0, bus.o_wr_en}, 32'd0);
        chk("mid_rst_addr", {24'd0, bus.o_wr_addr}, 32'd0);
        chk("mid_rst_data", {16'd0, bus.o_wr_data}, 32'd0);
        m_done = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b0;
        check_flags("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        w = {16'hBEEF, 16'hCAFE};
        run_frame(w, 8'h00, 1'b0, "after_rst");

`ifdef LOADER_TIMEOUT_EN
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("tmo_early", {31'd0, bus.o_error}, 32'd0);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_err  = 1'b1;
        m_hold = 1'b1;
        check_flags("tmo");
        repeat (4) @(negedge clk);
        check_flags("tmo_stay");
        w = {16'h1111};
        run_frame(w, 8'h00, 1'b0, "tmo_recover");
`endif

        for (int f = 0; f < 8; f++) begin
            int n;
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, 1'b0, 1);
            end
            w.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255))
                                            : 8'h00;
            run_frame(w, b, 1'($urandom_range(0, 1)), "rand");
        end

        w.delete();
        for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
        run_frame(w, 8'h00, 1'b1, "len256");
        repeat (3) @(negedge clk);
        chk("len256_idle_wr", {31'd0, bus.o_wr_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
